glb_ld_dma_addr_gen: RTL
========================

Name: glb_ld_dma_addr_gen

Overview:
Load-DMA address generator for one GLB tile. It consumes a dma_ld_header_t-style header and walks a LOOP_LEVEL-deep nested loop. Each cycle it emits one streaming read-request packet: packet_sel = {tile_id, PSEL_STRM}, plus rd_en and rd_addr. Its output feeds the tile's rdrq packet router / bank arbiter directly.

Parameters:
GLB_ADDR_WIDTH, 22, byte address width of rd_addr and start_addr
MAX_NUM_WORDS_WIDTH, 16, width of range, num_active_words, num_inactive_words
MAX_STRIDE_WIDTH, 16, width of each loop stride (bytes, unsigned)
LOOP_LEVEL, 3, number of nested loop levels (level 0 innermost)
TILE_SEL_ADDR_WIDTH, 4, width of tile_id / packet src

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
tile_id  in  TILE_SEL_ADDR_WIDTH  this tile's id, copied into rdrq_src
start  in  1  single-cycle start pulse
hdr_valid  in  1  header valid bit; start is ignored when 0
hdr_start_addr  in  GLB_ADDR_WIDTH  base byte address
hdr_range  in  LOOP_LEVEL*MAX_NUM_WORDS_WIDTH  per-level trip count, level 0 in LSBs
hdr_stride  in  LOOP_LEVEL*MAX_STRIDE_WIDTH  per-level byte stride, level 0 in LSBs
hdr_num_active_words  in  MAX_NUM_WORDS_WIDTH  burst length before an idle gap
hdr_num_inactive_words  in  MAX_NUM_WORDS_WIDTH  idle-gap length in cycles
stall  in  1  backpressure from downstream; freezes generation
rdrq_src  out  TILE_SEL_ADDR_WIDTH  packet_sel.src
rdrq_packet_type  out  2  packet_sel.packet_type (3 = PSEL_STRM when rd_en=1, else 0 = PSEL_NONE)
rdrq_rd_en  out  1  read request valid
rdrq_rd_addr  out  GLB_ADDR_WIDTH  read byte address
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last request is issued
stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- All outputs are registered. Header fields are captured on the accepted start edge; later header changes have no effect.
- Accept rule: start=1, hdr_valid=1 and state IDLE. Start while busy is ignored. Start with hdr_valid=0 is ignored, and done does not pulse.
- A range value of 0 is treated as 1. Total requests = product of effective ranges.
- Address: addr = start_addr + sum over i of (itr_i * stride_i). Maintain it incrementally with one accumulated offset per level. Arithmetic is modulo 2^GLB_ADDR_WIDTH (wrap silently).
- Iteration order: level 0 fastest. When itr_i reaches range_i-1, it resets to 0 and itr_(i+1) increments.
- States:
  - IDLE: on accept -> ACTIVE.
  - ACTIVE: on each edge with stall=0, register a request (rd_en=1, current addr) and advance the iterators.
    - After the final request -> DONE.
    - Else, if num_active_words≠0, num_inactive_words≠0 and the burst count reaches num_active_words -> INACTIVE.
  - INACTIVE: rd_en=0 for num_inactive_words non-stalled cycles, then -> ACTIVE with the burst count cleared.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- num_active_words=0 or num_inactive_words=0: no gaps; continuous stream.
- Latency: accept at edge T gives the first rd_en=1 visible after edge T+1. The sequence is back-to-back absent stall or gaps.
- Stall: on an edge with stall=1, rd_en is registered 0. No iterator, burst or inactive counter advances. The state is held.
- The last request coincides with the end of a burst: go directly to DONE, with no trailing gap.
- reset_n asserted mid-operation: immediate return to reset values. No done pulse.

Optional Feature:
Macro GLB_LD_DMA_STALL_CNT_EN.
- Defined: stall_cnt clears on accepted start. It increments (saturating at 2^32-1) on each edge where state is ACTIVE or INACTIVE and stall=1. It holds its value after done.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
1. start_addr=0x100, range={1,1,4}, stride={0,0,8}, no gaps -> rd_addr 0x100,0x108,0x110,0x118 on 4 consecutive cycles starting one cycle after start; done one cycle after the last request.
2. range={1,3,2}, stride={0,0x40,8}, start_addr=0 -> addrs 0x00,0x08,0x40,0x48,0x80,0x88; done once.
3. range0=6, stride0=8, active=2, inactive=3 -> pattern: 2 requests, 3 idle cycles, 2 requests, 3 idle cycles, 2 requests, done; no trailing gap.
4. Stall held 2 cycles mid-stream of test 1 -> no addresses skipped or duplicated; stream extends by 2 cycles; stall_cnt=2 with GLB_LD_DMA_STALL_CNT_EN.
5. start with hdr_valid=0 -> no rd_en, busy stays 0, no done; a second start during busy is ignored.
6. start_addr=0x3FFFF8, stride0=8, range0=2 -> addrs 0x3FFFF8 then 0x000000 (wrap); reset_n pulsed mid-stream -> outputs 0 immediately, no done.

Source files
------------

// File: rtl/glb_ld_dma_addr_gen.sv
// Load-DMA read-request address generator for one GLB tile: walks a nested loop, optional burst/gap shaping.
// Optional stall-cycle counter enabled by defining GLB_LD_DMA_STALL_CNT_EN.
module glb_ld_dma_addr_gen #(
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int MAX_NUM_WORDS_WIDTH = 16,
  parameter int MAX_STRIDE_WIDTH    = 16,
  parameter int LOOP_LEVEL          = 3,
  parameter int TILE_SEL_ADDR_WIDTH = 4
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [TILE_SEL_ADDR_WIDTH-1:0]            tile_id,
  input  logic                                      start,
  input  logic                                      hdr_valid,
  input  logic [GLB_ADDR_WIDTH-1:0]                 hdr_start_addr,
  input  logic [LOOP_LEVEL*MAX_NUM_WORDS_WIDTH-1:0] hdr_range,
  input  logic [LOOP_LEVEL*MAX_STRIDE_WIDTH-1:0]    hdr_stride,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0]            hdr_num_active_words,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0]            hdr_num_inactive_words,
  input  logic                                      stall,
  output logic [TILE_SEL_ADDR_WIDTH-1:0]            rdrq_src,
  output logic [1:0]                                rdrq_packet_type,
  output logic                                      rdrq_rd_en,
  output logic [GLB_ADDR_WIDTH-1:0]                 rdrq_rd_addr,
  output logic                                      busy,
  output logic                                      done,
  output logic [31:0]                               stall_cnt
);
  localparam int AW = GLB_ADDR_WIDTH;
  localparam int NW = MAX_NUM_WORDS_WIDTH;
  localparam int SW = MAX_STRIDE_WIDTH;
  localparam logic [NW-1:0] ONE_W = 1;
  localparam logic [1:0] PSEL_NONE = 2'd0;
  localparam logic [1:0] PSEL_STRM = 2'd3;

  typedef enum logic [1:0] {IDLE, ACTIVE, INACTIVE, DONE} state_t;
  state_t state_reg, state_next;

  logic [NW-1:0] hdr_rng [LOOP_LEVEL];
  logic [SW-1:0] hdr_str [LOOP_LEVEL];

  logic [AW-1:0] start_addr_reg;
  logic [NW-1:0] rng_m1_reg [LOOP_LEVEL];
  logic [AW-1:0] stride_reg [LOOP_LEVEL];
  logic [NW-1:0] itr_reg [LOOP_LEVEL];
  logic [NW-1:0] itr_next [LOOP_LEVEL];
  logic [AW-1:0] off_reg [LOOP_LEVEL];
  logic [AW-1:0] off_next [LOOP_LEVEL];
  logic [NW-1:0] active_words_reg, inactive_words_reg;
  logic [NW-1:0] burst_reg, burst_next, idle_reg, idle_next;

  logic [LOOP_LEVEL-1:0] last;
  logic [LOOP_LEVEL:0]   carry;
  logic                  accept, issue, final_req, gaps_en;
  logic [AW-1:0]         addr_cur;

  logic [TILE_SEL_ADDR_WIDTH-1:0] src_reg;
  logic [1:0]                     packet_type_reg;
  logic                           rd_en_reg, busy_reg, done_reg;
  logic [AW-1:0]                  rd_addr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LOOP_LEVEL; gi++) begin : g_lvl
      assign hdr_rng[gi] = hdr_range[gi*NW +: NW];
      assign hdr_str[gi] = hdr_stride[gi*SW +: SW];
      // rng_m1 already folds a range of 0 into a single iteration
      assign last[gi]    = (itr_reg[gi] == rng_m1_reg[gi]);
    end
  endgenerate

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < LOOP_LEVEL; i++) carry[i+1] = carry[i] & last[i];
  end

  always_comb begin
    addr_cur = start_addr_reg;
    for (int i = 0; i < LOOP_LEVEL; i++) addr_cur = addr_cur + off_reg[i];
  end

  assign accept    = start && hdr_valid && (state_reg == IDLE);
  assign issue     = (state_reg == ACTIVE) && !stall;
  assign final_req = carry[LOOP_LEVEL];
  assign gaps_en   = (active_words_reg != '0) && (inactive_words_reg != '0);

  always_comb begin
    state_next = state_reg;
    burst_next = burst_reg;
    idle_next  = idle_reg;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      itr_next[i] = itr_reg[i];
      off_next[i] = off_reg[i];
    end
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = ACTIVE;
          burst_next = '0;
          idle_next  = '0;
          for (int i = 0; i < LOOP_LEVEL; i++) begin
            itr_next[i] = '0;
            off_next[i] = '0;
          end
        end
      end
      ACTIVE: begin
        if (!stall) begin
          for (int i = 0; i < LOOP_LEVEL; i++) begin
            if (carry[i]) begin
              if (last[i]) begin
                itr_next[i] = '0;
                off_next[i] = '0;
              end else begin
                itr_next[i] = itr_reg[i] + ONE_W;
                off_next[i] = off_reg[i] + stride_reg[i];
              end
            end
          end
          burst_next = burst_reg + ONE_W;
          // final request wins over a gap so there is never a trailing idle period
          if (final_req) begin
            state_next = DONE;
          end else if (gaps_en && (burst_next == active_words_reg)) begin
            state_next = INACTIVE;
            burst_next = '0;
          end
        end
      end
      INACTIVE: begin
        if (!stall) begin
          if (idle_reg + ONE_W == inactive_words_reg) begin
            state_next = ACTIVE;
            idle_next  = '0;
          end else begin
            idle_next = idle_reg + ONE_W;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      start_addr_reg     <= '0;
      active_words_reg   <= '0;
      inactive_words_reg <= '0;
      burst_reg          <= '0;
      idle_reg           <= '0;
      for (int i = 0; i < LOOP_LEVEL; i++) begin
        rng_m1_reg[i] <= '0;
        stride_reg[i] <= '0;
        itr_reg[i]    <= '0;
        off_reg[i]    <= '0;
      end
    end else begin
      state_reg <= state_next;
      burst_reg <= burst_next;
      idle_reg  <= idle_next;
      for (int i = 0; i < LOOP_LEVEL; i++) begin
        itr_reg[i] <= itr_next[i];
        off_reg[i] <= off_next[i];
      end
      if (accept) begin
        start_addr_reg     <= hdr_start_addr;
        active_words_reg   <= hdr_num_active_words;
        inactive_words_reg <= hdr_num_inactive_words;
        for (int i = 0; i < LOOP_LEVEL; i++) begin
          rng_m1_reg[i] <= (hdr_rng[i] == '0) ? '0 : hdr_rng[i] - ONE_W;
          stride_reg[i] <= AW'(hdr_str[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_reg         <= '0;
      packet_type_reg <= PSEL_NONE;
      rd_en_reg       <= 1'b0;
      rd_addr_reg     <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      src_reg         <= tile_id;
      packet_type_reg <= issue ? PSEL_STRM : PSEL_NONE;
      rd_en_reg       <= issue;
      if (issue) rd_addr_reg <= addr_cur;
      busy_reg        <= (state_next != IDLE);
      done_reg        <= (state_reg == DONE);
    end
  end

  assign rdrq_src         = src_reg;
  assign rdrq_packet_type = packet_type_reg;
  assign rdrq_rd_en       = rd_en_reg;
  assign rdrq_rd_addr     = rd_addr_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;

`ifdef GLB_LD_DMA_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
    end else if (accept) begin
      stall_cnt_reg <= '0;
    end else if (((state_reg == ACTIVE) || (state_reg == INACTIVE)) && stall
                 && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule
